spi_peripheral: RTL and testbench
=================================

# spi_peripheral

SPI-slave register bank that receives 16-bit write frames from an external controller and holds the five 8-bit control registers consumed by `pwm_peripheral`: output enables, PWM enables and the shared duty cycle. It sits between the SPI pins (`ui_in[2:0]`) and the PWM stage inside the TinyTapeout top. The top drives its `rst` input from `~rst_n`.

## Interface
Parameters:
- `NUM_REGS`, 5: number of implemented registers, at addresses 0x00 to NUM_REGS-1.
- `SYNC_STAGES`, 2: synchronizer depth per SPI input, not counting the edge-detect flop.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, asynchronous and active-high.
- `sclk`  in  1  SPI clock (`ui_in[0]`), asynchronous to `clk`.
- `copi`  in  1  SPI data in (`ui_in[1]`), asynchronous.
- `ncs`  in  1  SPI chip select, active-low (`ui_in[2]`), asynchronous.
- `en_reg_out_7_0`  out  8  reg 0x00.
- `en_reg_out_15_8`  out  8  reg 0x01.
- `en_reg_pwm_7_0`  out  8  reg 0x02.
- `en_reg_pwm_15_8`  out  8  reg 0x03.
- `pwm_duty_cycle`  out  8  reg 0x04.

## Operation
- SPI mode 0: data is sampled on the synchronized `sclk` rising edge, MSB first.
- Frame is 16 bits:
  - bit15: R/W (1 = write, 0 = read).
  - bits14:8: 7-bit address.
  - bits7:0: data.
- Reads are accepted on the wire but have no effect. There is no `cipo` pin.
- Each of `sclk`, `copi`, `ncs` passes through `SYNC_STAGES` flops, then one extra flop used for edge detection.
  - Edges are detected from the last two stages.
  - `copi` is captured from the synchronized copy, aligned to the `sclk` edge pulse.
- State machine:
  - IDLE: wait for the `ncs` falling edge, then clear the bit counter and shift register and go to SHIFT.
  - SHIFT: on each `sclk` rising edge while `ncs` is low, shift `copi` in and increment the 5-bit counter. The counter saturates at 17. An `ncs` rising edge moves to COMMIT.
  - COMMIT (one cycle): if counter == 16, R/W == 1 and address < NUM_REGS, load the data into the addressed register. Always return to IDLE.
- Frames with counter ≠ 16 (short or long) are discarded whole. No register changes.
- Writes to address ≥ NUM_REGS are silently dropped.
- `sclk` edges while `ncs` is high are ignored.
- All registers and outputs reset to 0x00. Registers hold their values between frames.
- `rst` asserted mid-frame: the frame is aborted, the FSM goes to IDLE, all registers go to 0x00. After release, the first `ncs` falling edge starts a fresh frame.

## Timing
- Input constraints:
  - `sclk` high and low phases are each ≥ 3 `clk` periods.
  - `ncs` stays low ≥ 3 `clk` periods after the last `sclk` fall.
  - Minimum `ncs` high time between frames is 3 `clk` periods.
- `copi` is stable from ≥ 1 `clk` before to ≥ 1 `clk` after each `sclk` rise (standard mode 0 setup/hold, widened for synchronization).
- Write latency: a register output updates 4 `clk` edges after `ncs` rises at the pin. That is 2 sync stages, 1 edge detect, and 1 COMMIT state. The COMMIT state registers directly into the outputs.
- Outputs are glitch-free registered values. A register changes at most once per frame.
- Simultaneous `ncs` rise and `sclk` rise in the same synchronized cycle: the `sclk` edge is processed first, then COMMIT evaluates the updated counter.

## Structure
- Package `spi_pkg`:
  - `FRAME_BITS = 16`.
  - Address constants `ADDR_EN_OUT_LO = 7'h00` through `ADDR_DUTY = 7'h04`.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module `sync_edge`: parameterised synchronizer plus rising/falling edge pulse generator. Instantiated once each for `sclk`, `copi` and `ncs`; the `copi` instance uses only the level output.
- Registers are stored as an array of `NUM_REGS` × 8 and broken out to the five named ports.

## Test plan
- After reset, write 0x80_F0 (addr 0x00, data 0xF0), then 0x81_0F → `en_reg_out_7_0`=0xF0 and `en_reg_out_15_8`=0x0F. All others stay 0x00. Each update lands 4 `clk` after `ncs` rises.
- Write 0x84_80 → `pwm_duty_cycle`=0x80. Then read frame 0x04_FF → `pwm_duty_cycle` remains 0x80.
- Write 0x85_AA and 0xFF_55 (invalid addresses) → all five registers unchanged.
- Frames of 15 bits and of 17 bits carrying 0x82_33 → `en_reg_pwm_7_0` remains 0x00. A following valid 16-bit 0x82_33 sets it to 0x33.
- Assert `rst` after 8 bits of 0x83_FF, release, then send a full 0x83_C3 → no partial write. `en_reg_pwm_15_8`=0x00 after reset and 0xC3 after the new frame.
- `sclk` toggled 16 times with `ncs` high, then a valid frame 0x84_10 → only the valid frame takes effect: `pwm_duty_cycle`=0x10.

Source files
------------

// File: rtl/spi_peripheral_pkg.sv
// spi_pkg: shared constants and types for the SPI register bank.
//   FRAME_BITS    - length of a valid write frame on the wire
//   ADDR_*        - register addresses of the five PWM control registers
//   state_t       - frame-handling FSM states
package spi_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_peripheral_if.sv
// spi_peripheral_if: the three SPI pins as seen by the register bank.
//   sclk - SPI clock, copi - controller-out data, ncs - active-low select
//   master modport drives the pins (external controller / bench),
//   slave modport samples them (spi_peripheral).
interface spi_peripheral_if;

  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);

endinterface

// File: rtl/spi_peripheral_sync_edge.sv
// sync_edge: multi-flop synchronizer for one asynchronous input plus a
// rising/falling pulse generator.
//   clk, rst - system clock, async active-high reset
//   din      - asynchronous input
//   level    - synchronized copy of din (after STAGES flops)
//   rise     - one-cycle pulse when level goes 0 -> 1
//   fall     - one-cycle pulse when level goes 1 -> 0
// RST_VAL lets idle-high inputs (chip select) come out of reset without a
// spurious edge.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // chain[STAGES-1] is the synchronized level, chain[STAGES] the delayed
  // copy used only for edge detection.
  logic [STAGES:0] chain;

  // Shift the input through the synchronizer and edge-detect flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {(STAGES + 1){RST_VAL}};
    end else begin
      chain <= {chain[STAGES-1:0], din};
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~chain[STAGES];
  assign fall  = ~chain[STAGES-1] & chain[STAGES];

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 slave holding the PWM control registers.
//   clk, rst          - system clock, async active-high reset
//   spi               - SPI pins (sclk, copi, ncs), all asynchronous
//   en_reg_out_7_0    - register 0x00    en_reg_out_15_8 - register 0x01
//   en_reg_pwm_7_0    - register 0x02    en_reg_pwm_15_8 - register 0x03
//   pwm_duty_cycle    - register 0x04
// Frames are {rw, addr[6:0], data[7:0]} MSB first; only complete 16-bit
// write frames to an implemented address change a register.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_peripheral_if.slave   spi,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle
);

  localparam int         IDX_W    = $clog2(NUM_REGS);
  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  logic sclk_level_unused, sclk_rise, sclk_fall_unused;
  logic copi_level, copi_rise_unused, copi_fall_unused;
  logic ncs_level_unused, ncs_rise, ncs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(spi.sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(spi.copi),
    .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  // Chip select idles high, so its synchronizer resets high as well.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(spi.ncs),
    .level(ncs_level_unused), .rise(ncs_rise), .fall(ncs_fall)
  );

  state_t                  state, next_state;
  logic [4:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [7:0]              regs [NUM_REGS];
  logic                    clear, shift_en, commit, write_ok;
  logic [6:0]              frame_addr;
  logic [7:0]              frame_data;

  assign frame_addr = shift_reg[FRAME_BITS-2:8];
  assign frame_data = shift_reg[7:0];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. In SHIFT an sclk edge coinciding with the
  // ncs rise is still shifted, so COMMIT sees the updated counter.
  always_comb begin
    next_state = state;
    clear      = 1'b0;
    shift_en   = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          clear      = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
        shift_en = sclk_rise;
        if (ncs_rise) begin
          next_state = COMMIT;
        end else begin
          next_state = SHIFT;
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // A frame is accepted only if it was exactly 16 bits, a write, and in range.
  always_comb begin
    write_ok = (bit_cnt == CNT_FULL) && shift_reg[FRAME_BITS-1] &&
               (frame_addr < 7'(NUM_REGS));
  end

  // Shift register and saturating bit counter; saturation keeps long frames
  // from wrapping back to a count of 16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 5'd0;
      shift_reg <= {FRAME_BITS{1'b0}};
    end else if (clear) begin
      bit_cnt   <= 5'd0;
      shift_reg <= {FRAME_BITS{1'b0}};
    end else if (shift_en) begin
      shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_level};
      if (bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  // Register bank, written only in the single COMMIT cycle of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (commit && write_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (frame_addr == 7'(i)) begin
          regs[i] <= frame_data;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs[IDX_W'(ADDR_EN_OUT_LO)];
  assign en_reg_out_15_8 = regs[IDX_W'(ADDR_EN_OUT_HI)];
  assign en_reg_pwm_7_0  = regs[IDX_W'(ADDR_EN_PWM_LO)];
  assign en_reg_pwm_15_8 = regs[IDX_W'(ADDR_EN_PWM_HI)];
  assign pwm_duty_cycle  = regs[IDX_W'(ADDR_DUTY)];

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed bench for spi_peripheral. Drives SPI frames
// bit by bit, keeps the expected register contents in exp[], and checks all
// five outputs one clk before and exactly at the 4-clk write latency.
module tb_spi_peripheral;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle;
  logic [7:0] obs [5];
  logic [7:0] exp [5];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_peripheral_if spi ();

  spi_peripheral #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .spi(spi.slave),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle)
  );

  assign obs[0] = en_reg_out_7_0;
  assign obs[1] = en_reg_out_15_8;
  assign obs[2] = en_reg_pwm_7_0;
  assign obs[3] = en_reg_pwm_15_8;
  assign obs[4] = pwm_duty_cycle;

  task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s_reg%0d", tag, i), obs[i], exp[i]);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MSB-first bits, copi set 3 clk before each sclk rise, 4 clk high phase.
  task automatic shift_bits(input logic [31:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi.copi = b[i];
      wait_clks(3);
      spi.sclk = 1'b1;
      wait_clks(4);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] b, input int n);
    spi.ncs = 1'b0;
    wait_clks(4);
    shift_bits(b, n);
    wait_clks(4);
    spi.ncs = 1'b1;
  endtask

  // ncs has just risen at a negedge: nothing may change after 3 clk edges,
  // the expected update must be visible after the 4th.
  task automatic settle(input string tag, input int idx, input logic [7:0] val, input bit upd);
    wait_clks(3);
    check_all({tag, "_pre"});
    if (upd) exp[idx] = val;
    wait_clks(1);
    check_all({tag, "_post"});
    wait_clks(4);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    for (int i = 0; i < 5; i++) exp[i] = 8'h00;
    wait_clks(3);
    check_all("reset");
    rst = 1'b0;
    wait_clks(4);

    send_frame(32'h0000_80F0, 16); settle("w_out_lo", 0, 8'hF0, 1'b1);
    send_frame(32'h0000_810F, 16); settle("w_out_hi", 1, 8'h0F, 1'b1);
    send_frame(32'h0000_8480, 16); settle("w_duty",   4, 8'h80, 1'b1);
    send_frame(32'h0000_04FF, 16); settle("read",     4, 8'h00, 1'b0);
    send_frame(32'h0000_85AA, 16); settle("bad_addr5", 0, 8'h00, 1'b0);
    send_frame(32'h0000_FF55, 16); settle("bad_addr7f", 0, 8'h00, 1'b0);

    // Top 15 bits of 0x8233, then 0x8233 preceded by an extra 1 bit.
    send_frame(32'h0000_4119, 15); settle("short15", 2, 8'h00, 1'b0);
    send_frame(32'h0001_8233, 17); settle("long17",  2, 8'h00, 1'b0);
    send_frame(32'h0000_8233, 16); settle("w_pwm_lo", 2, 8'h33, 1'b1);

    // Reset in the middle of 0x83_FF after 8 bits.
    spi.ncs = 1'b0;
    wait_clks(4);
    shift_bits(32'h0000_0083, 8);
    rst = 1'b1;
    wait_clks(2);
    for (int i = 0; i < 5; i++) exp[i] = 8'h00;
    check_all("mid_rst");
    rst = 1'b0;
    wait_clks(4);
    spi.ncs = 1'b1;
    wait_clks(8);
    check_all("after_rst");
    send_frame(32'h0000_83C3, 16); settle("w_pwm_hi", 3, 8'hC3, 1'b1);

    // sclk activity with ncs high must be ignored.
    for (int i = 0; i < 16; i++) begin
      spi.copi = 1'b1;
      wait_clks(3);
      spi.sclk = 1'b1;
      wait_clks(4);
      spi.sclk = 1'b0;
    end
    wait_clks(4);
    check_all("sclk_idle");
    send_frame(32'h0000_8410, 16); settle("w_duty2", 4, 8'h10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
